// File: rtl/vec_u_sched_if.sv
// -----------------------------------------------------------------------------
// vec_u_sched_if
// Requester-side bus of the vector-unit command scheduler.
//   cmd_valid[1:0]   per-requester command valid (bit i = requester i)
//   cmd_ready[1:0]   per-requester accept, transfer when valid & ready
//   cmd_opN          0 = write, 1 = compute
//   cmd_addrN        write address
//   cmd_dataN        write data
//   cmd_modN         compute mode (00 A+B, 01 A-B, 10 B, 11 A)
//   rsp_valid        one-cycle result strobe, no backpressure
//   rsp_id           requester that issued the compute
//   rsp_ptr          pair base pointer consumed by the compute
//   rsp_data         captured result, held until the next response
// master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface vec_u_sched_if #(
  parameter int Size = 256
);
  logic [1:0]      cmd_valid;
  logic [1:0]      cmd_ready;
  logic            cmd_op0;
  logic            cmd_op1;
  logic [5:0]      cmd_addr0;
  logic [5:0]      cmd_addr1;
  logic [Size-1:0] cmd_data0;
  logic [Size-1:0] cmd_data1;
  logic [1:0]      cmd_mod0;
  logic [1:0]      cmd_mod1;
  logic            rsp_valid;
  logic            rsp_id;
  logic [5:0]      rsp_ptr;
  logic [Size-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op0, cmd_op1, cmd_addr0, cmd_addr1,
           cmd_data0, cmd_data1, cmd_mod0, cmd_mod1,
    input  cmd_ready, rsp_valid, rsp_id, rsp_ptr, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op0, cmd_op1, cmd_addr0, cmd_addr1,
           cmd_data0, cmd_data1, cmd_mod0, cmd_mod1,
    output cmd_ready, rsp_valid, rsp_id, rsp_ptr, rsp_data
  );
endinterface

// File: rtl/vec_u_sched.sv
// -----------------------------------------------------------------------------
// vec_u_sched
// Command scheduler in front of the single-URAM vector unit. Arbitrates two
// requesters (round-robin) onto the unit's write port and read trigger, parks
// the write port on scratch address 0 when idle, and sequences each compute
// (ISSUE -> fixed-latency WAIT -> CAPTURE), returning the result tagged with
// requester ID and pair pointer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           requester bus (vec_u_sched_if.slave)
//   vu_addr       vector unit write address (0 when no write)
//   vu_data_in    vector unit write data (0 when no write)
//   vu_mod        vector unit mode, held from ISSUE through CAPTURE
//   vu_en_read    vector unit read trigger (one cycle, in ISSUE)
//   vu_out        vector unit result, sampled in CAPTURE
//   busy          high in every state except IDLE
// -----------------------------------------------------------------------------
module vec_u_sched #(
  parameter int Size   = 256,
  parameter int OP_LAT = 7
) (
  input  logic            clk,
  input  logic            rst,
  vec_u_sched_if.slave    bus,
  output logic [5:0]      vu_addr,
  output logic [Size-1:0] vu_data_in,
  output logic [1:0]      vu_mod,
  output logic            vu_en_read,
  input  logic [Size-1:0] vu_out,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  // WAIT spans OP_LAT-1 cycles; the counter starts at 0 on entry.
  localparam logic [3:0] CNT_LAST = 4'(OP_LAT - 2);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [5:0]      rd_ptr_q, rd_ptr_d;
  logic [5:0]      ptr_q, ptr_d;
  logic            last_gnt_q, last_gnt_d;
  logic            id_q, id_d;
  logic [1:0]      mod_q, mod_d;
  logic [5:0]      wr_addr_q, wr_addr_d;
  logic [Size-1:0] wr_data_q, wr_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [5:0]      rsp_ptr_q, rsp_ptr_d;
  logic [Size-1:0] rsp_data_q, rsp_data_d;

  logic            gnt_id;
  logic            can_accept;
  logic            sel_op;
  logic [5:0]      sel_addr;
  logic [Size-1:0] sel_data;
  logic [1:0]      sel_mod;

  // Arbitration: a lone requester wins; on conflict the one that did not
  // win the last accepted transfer wins.
  always_comb begin
    gnt_id     = (bus.cmd_valid == 2'b11) ? ~last_gnt_q : bus.cmd_valid[1];
    can_accept = (state_q == IDLE) && !rst && (|bus.cmd_valid);
    sel_op     = gnt_id ? bus.cmd_op1   : bus.cmd_op0;
    sel_addr   = gnt_id ? bus.cmd_addr1 : bus.cmd_addr0;
    sel_data   = gnt_id ? bus.cmd_data1 : bus.cmd_data0;
    sel_mod    = gnt_id ? bus.cmd_mod1  : bus.cmd_mod0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    ptr_d       = ptr_q;
    last_gnt_d  = last_gnt_q;
    id_d        = id_q;
    mod_d       = mod_q;
    wr_addr_d   = 6'd0;          // write port parks on scratch address 0
    wr_data_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_ptr_d   = rsp_ptr_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (can_accept) begin
          last_gnt_d = gnt_id;
          if (sel_op) begin
            mod_d   = sel_mod;
            id_d    = gnt_id;
            ptr_d   = rd_ptr_q;
            state_d = ISSUE;
          end else begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
          end
        end
      end
      ISSUE: begin
        rd_ptr_d = rd_ptr_q + 6'd2;  // wraps 62 -> 0
        cnt_d    = 4'd0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_ptr_d   = ptr_q;
        rsp_data_d  = vu_out;
        cnt_d       = 4'd0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rd_ptr_q    <= 6'd0;
      ptr_q       <= 6'd0;
      last_gnt_q  <= 1'b1;
      id_q        <= 1'b0;
      mod_q       <= 2'd0;
      wr_addr_q   <= 6'd0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_ptr_q   <= 6'd0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      ptr_q       <= ptr_d;
      last_gnt_q  <= last_gnt_d;
      id_q        <= id_d;
      mod_q       <= mod_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ptr_q   <= rsp_ptr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Outputs are forced low while rst is high, including the first reset
  // cycle before the registers have been cleared.
  assign bus.cmd_ready = can_accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = rst ? 1'b0 : rsp_valid_q;
  assign bus.rsp_id    = rst ? 1'b0 : rsp_id_q;
  assign bus.rsp_ptr   = rst ? 6'd0 : rsp_ptr_q;
  assign bus.rsp_data  = rst ? '0   : rsp_data_q;
  assign vu_addr       = rst ? 6'd0 : wr_addr_q;
  assign vu_data_in    = rst ? '0   : wr_data_q;
  assign vu_mod        = rst ? 2'd0 : mod_q;
  assign vu_en_read    = !rst && (state_q == ISSUE);
  assign busy          = !rst && (state_q != IDLE);

endmodule
